// File: rtl/knn_sched.sv
// knn_sched: walks the training ROM one instance at a time through update_knn, then runs knn_vote once.
// Optional watchdog under macro KNN_TIMEOUT_EN aborts a stalled handshake after TIMEOUT_CYC cycles.
module knn_sched #(
  parameter int TRAIN_PER_DIGIT = 180,
  parameter int ADDR_W          = 15,
  parameter int TIMEOUT_CYC     = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [3:0]        digit_out,
  output logic              err,
  output logic [ADDR_W-1:0] train_addr,
  output logic              train_ce,
  output logic              upd_start,
  input  logic              upd_done,
  output logic [3:0]        upd_offset,
  output logic              vote_start,
  input  logic              vote_done,
  input  logic [3:0]        vote_result
);

  localparam int IDX_W = (TRAIN_PER_DIGIT > 1) ? $clog2(TRAIN_PER_DIGIT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(10 * TRAIN_PER_DIGIT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(TRAIN_PER_DIGIT - 1);

  if (TRAIN_PER_DIGIT < 1 || ADDR_W > 30 || (10 * TRAIN_PER_DIGIT) > (1 << ADDR_W) || TIMEOUT_CYC < 1)
  begin : g_bad_cfg
    $error("knn_sched: invalid parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_UPD,
    S_VOTE,
    S_FIN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [3:0]        cls_nxt;
  logic [3:0]        digit_nxt;
  logic              timeout;

`ifdef KNN_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  logic [WAIT_W-1:0] wait_cnt;

  // Counter restarts on every state change, so each UPD/VOTE visit gets a full window.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_nxt != state) begin
      wait_cnt <= '0;
    end else if (state == S_UPD || state == S_VOTE) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = (state == S_UPD || state == S_VOTE) && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == S_IDLE && start) begin
      err <= 1'b0;
    end else if ((state == S_UPD && !upd_done && timeout) ||
                 (state == S_VOTE && !vote_done && timeout)) begin
      err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = train_addr;
    idx_nxt   = idx;
    cls_nxt   = upd_offset;
    digit_nxt = digit_out;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
          addr_nxt  = '0;
          idx_nxt   = '0;
          cls_nxt   = 4'd0;
        end
      end
      S_FETCH: state_nxt = S_UPD;
      S_UPD: begin
        if (upd_done) begin
          if (train_addr == LAST_ADDR) begin
            state_nxt = S_VOTE;
          end else begin
            state_nxt = S_FETCH;
            addr_nxt  = train_addr + 1'b1;
            // Class advances only when the within-class index wraps.
            if (idx == LAST_IDX) begin
              idx_nxt = '0;
              cls_nxt = upd_offset + 4'd1;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end
        end else if (timeout) begin
          state_nxt = S_FIN;
          digit_nxt = 4'hF;
        end
      end
      S_VOTE: begin
        if (vote_done) begin
          state_nxt = S_FIN;
          digit_nxt = vote_result;
        end else if (timeout) begin
          state_nxt = S_FIN;
          digit_nxt = 4'hF;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      train_ce   <= 1'b0;
      upd_start  <= 1'b0;
      vote_start <= 1'b0;
      train_addr <= '0;
      upd_offset <= 4'd0;
      digit_out  <= 4'd0;
      idx        <= '0;
    end else begin
      busy       <= (state_nxt != S_IDLE);
      done       <= (state_nxt == S_FIN);
      train_ce   <= (state_nxt == S_FETCH);
      upd_start  <= (state_nxt == S_UPD);
      vote_start <= (state_nxt == S_VOTE);
      train_addr <= addr_nxt;
      upd_offset <= cls_nxt;
      digit_out  <= digit_nxt;
      idx        <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_knn_sched.sv
// Directed/randomized bench for knn_sched with a cycle-count reference model of one recognition run.
module tb_knn_sched;
  localparam int TPD = 2;
  localparam int N   = 10 * TPD;
  localparam int TO  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [3:0]  digit_out;
  logic        err;
  logic [14:0] train_addr;
  logic        train_ce;
  logic        upd_start;
  logic        upd_done;
  logic [3:0]  upd_offset;
  logic        vote_start;
  logic        vote_done;
  logic [3:0]  vote_result;

  int n_assert = 0;
  int n_fail   = 0;
  int upd_lat[N];

  knn_sched #(.TRAIN_PER_DIGIT(TPD), .ADDR_W(15), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .digit_out(digit_out), .err(err), .train_addr(train_addr), .train_ce(train_ce),
    .upd_start(upd_start), .upd_done(upd_done), .upd_offset(upd_offset),
    .vote_start(vote_start), .vote_done(vote_done), .vote_result(vote_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each instance costs one fetch cycle plus its update latency,
  // then the vote latency, then done appears one cycle later.
  function automatic int exp_done_cyc(input int vlat);
    int s = 0;
    for (int i = 0; i < N; i++) s += 1 + upd_lat[i];
    return s + vlat + 1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; upd_done = 1'b0; vote_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_run(input string tag, input int vlat, input logic [3:0] vres, input bit hold);
    int cyc = 0, inst = 0, ucnt = 0, vcnt = 0, pulses = 0, ce_cyc = 0;
    int addr_err = 0, off_err = 0, done_cyc = -1;
    bit prev_us = 1'b0;
    @(negedge clk);
    start = 1'b1; upd_done = 1'b0; vote_done = 1'b0;
    while (done_cyc < 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!hold) start = 1'b0;
      upd_done = 1'b0; vote_done = 1'b0;
      vote_result = 4'($urandom);
      if (train_ce) ce_cyc++;
      if (upd_start && !prev_us) begin
        pulses++;
        if (int'(train_addr) != inst) addr_err++;
        if (int'(upd_offset) != inst / TPD) off_err++;
      end
      prev_us = upd_start;
      if (upd_start && inst < N) begin
        ucnt++;
        if (ucnt == upd_lat[inst]) begin upd_done = 1'b1; ucnt = 0; inst++; end
      end
      if (vote_start) begin
        vcnt++;
        if (vcnt == vlat) begin vote_done = 1'b1; vote_result = vres; end
      end
      if (done) done_cyc = cyc;
    end
    upd_done = 1'b0; vote_done = 1'b0;
    chk({tag, "_upd_pulses"}, pulses, N);
    chk({tag, "_ce_cycles"}, ce_cyc, N);
    chk({tag, "_addr_seq_errs"}, addr_err, 0);
    chk({tag, "_offset_seq_errs"}, off_err, 0);
    chk({tag, "_done_cycle"}, done_cyc, exp_done_cyc(vlat));
    chk({tag, "_digit_out"}, digit_out, vres);
    chk({tag, "_err"}, err, 0);
    @(negedge clk);
    chk({tag, "_done_width"}, done, 0);
    chk({tag, "_busy_after_fin"}, busy, 0);
    chk({tag, "_digit_held"}, digit_out, vres);
  endtask

  initial begin
    int guard;
    int done_seen;
    int bad_busy;
    int bad_err;
    logic [3:0] vr;
    rst = 1'b1; start = 1'b0; upd_done = 1'b0; vote_done = 1'b0; vote_result = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ce", train_ce, 0);
    chk("rst_upd_start", upd_start, 0);
    chk("rst_vote_start", vote_start, 0);
    chk("rst_addr", train_addr, 0);
    chk("rst_offset", upd_offset, 0);
    chk("rst_digit", digit_out, 0);

    // Nominal: update answers on its 2nd cycle, vote on its 3rd with 7.
    for (int i = 0; i < N; i++) upd_lat[i] = 2;
    chk("nominal_model_64", exp_done_cyc(3), 64);
    do_run("nominal", 3, 4'd7, 1'b0);

    // Reset while updating instance 5.
    @(negedge clk);
    start = 1'b1;
    guard = 0; done_seen = 0;
    while (!(upd_start && train_addr == 15'd5) && guard < 200) begin
      @(negedge clk);
      start = 1'b0;
      upd_done = upd_start && (train_addr != 15'd5);
      if (done) done_seen++;
      guard++;
    end
    chk("midrst_reached_addr5", train_addr, 5);
    upd_done = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_upd_start", upd_start, 0);
    chk("midrst_addr", train_addr, 0);
    chk("midrst_offset", upd_offset, 0);
    chk("midrst_digit", digit_out, 0);
    chk("midrst_no_done", done_seen, 0);
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_after_rst_busy", busy, 1);
    chk("start_after_rst_ce", train_ce, 1);
    do_reset();

    // Randomized latencies and results.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) upd_lat[i] = $urandom_range(1, 4);
      vr = 4'($urandom_range(0, 9));
      do_run("random", $urandom_range(1, 5), vr, 1'b0);
    end

    // Start held through the whole run: one run, then restart only from IDLE.
    for (int i = 0; i < N; i++) upd_lat[i] = $urandom_range(1, 3);
    do_run("held", 2, 4'd4, 1'b1);
    @(negedge clk);
    chk("held_restart_busy", busy, 1);
    chk("held_restart_ce", train_ce, 1);
    chk("held_restart_addr", train_addr, 0);
    do_reset();

    // Spurious done strobes in IDLE and FETCH.
    upd_done = 1'b1; vote_done = 1'b1; vote_result = 4'd3;
    repeat (3) @(negedge clk);
    chk("spur_idle_busy", busy, 0);
    chk("spur_idle_done", done, 0);
    chk("spur_idle_digit", digit_out, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("spur_fetch_ce", train_ce, 1);
    chk("spur_fetch_upd_start", upd_start, 0);
    @(negedge clk);
    upd_done = 1'b0; vote_done = 1'b0;
    chk("spur_upd_entered", upd_start, 1);
    chk("spur_upd_addr", train_addr, 0);
    chk("spur_vote_start", vote_start, 0);
    chk("spur_digit", digit_out, 0);
    do_reset();

    // Update never answers.
    @(negedge clk);
    start = 1'b1;
`ifdef KNN_TIMEOUT_EN
    guard = 0; done_seen = -1;
    while (done_seen < 0 && guard < 100) begin
      @(negedge clk);
      start = 1'b0;
      guard++;
      if (done) done_seen = guard;
    end
    chk("to_done_cycle", done_seen, TO + 2);
    chk("to_err", err, 1);
    chk("to_digit", digit_out, 4'hF);
    chk("to_upd_start", upd_start, 0);
    @(negedge clk);
    chk("to_err_sticky", err, 1);
    chk("to_idle", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("to_err_cleared", err, 0);
    chk("to_restart_busy", busy, 1);
`else
    bad_busy = 0; bad_err = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (!busy) bad_busy++;
      if (err) bad_err++;
    end
    chk("stall_busy_low_cycles", bad_busy, 0);
    chk("stall_err_cycles", bad_err, 0);
    chk("stall_upd_start", upd_start, 1);
    chk("stall_done", done, 0);
`endif
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
